// File: rtl/arm_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arm_mem_pkg
// Brief    : Shared types and constants for the instruction/data SRAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package arm_mem_pkg;

    localparam int unsigned C_WAIT_CYCLES_DEFAULT = 4;
    localparam int unsigned C_CNT_W               = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/wait_counter.sv
`default_nettype none
// ============================================================================
// Module   : wait_counter
// Brief    : Up-counter with synchronous load-to-zero and terminal-count flag.
// Revision : 1.0 - initial release
// ============================================================================
module wait_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned TERMINAL = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic tc
);

    localparam logic [WIDTH-1:0] C_TERMINAL = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign tc = (r_count == C_TERMINAL);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Arbitrates fetch and data-stage requests onto one multi-cycle SRAM
//            port; data requests have fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import arm_mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = C_WAIT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        freeze,
    output logic        sram_en,
    output logic        sram_we,
    output logic [29:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    state_t r_state;
    owner_t r_owner;
    logic   w_mem_req;
    logic   w_last_cycle;
    logic   w_unused_addr_bits;

    assign w_mem_req          = mem_r_en | mem_w_en;
    assign w_unused_addr_bits = ^{if_addr[1:0], mem_addr[1:0]};

    assign freeze = (if_req & ~if_ready) | (w_mem_req & ~mem_ready);

    wait_counter #(
        .WIDTH    (C_CNT_W),
        .TERMINAL (WAIT_CYCLES - 1)
    ) u_wait_counter (
        .clk    (clk),
        .rst    (rst),
        .load   (r_state == IDLE),
        .enable (r_state == ACCESS),
        .tc     (w_last_cycle)
    );

    // The SRAM address/wdata/we registers double as the latched request, so
    // input changes after the IDLE cycle cannot reach the SRAM bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_owner    <= OWN_IF;
            if_rdata   <= '0;
            mem_rdata  <= '0;
            if_ready   <= 1'b0;
            mem_ready  <= 1'b0;
            sram_en    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mem_req) begin
                        r_owner    <= OWN_MEM;
                        sram_en    <= 1'b1;
                        sram_we    <= mem_w_en;
                        sram_addr  <= mem_addr[31:2];
                        sram_wdata <= mem_wdata;
                        r_state    <= ACCESS;
                    end else if (if_req) begin
                        r_owner    <= OWN_IF;
                        sram_en    <= 1'b1;
                        sram_we    <= 1'b0;
                        sram_addr  <= if_addr[31:2];
                        r_state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (w_last_cycle) begin
                        sram_en <= 1'b0;
                        sram_we <= 1'b0;
                        if (r_owner == OWN_MEM) begin
                            mem_ready <= 1'b1;
                            if (!sram_we) begin
                                mem_rdata <= sram_rdata;
                            end
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= sram_rdata;
                        end
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if_ready  <= 1'b0;
                    mem_ready <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Scoreboard bench for mem_arbiter with WAIT_CYCLES = 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int C_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        freeze;
    logic        sram_en;
    logic        sram_we;
    logic [29:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    typedef struct {
        logic        is_mem;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sram_mem [1024];

    mem_arbiter #(.WAIT_CYCLES(C_WAIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_ready   (if_ready),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .freeze     (freeze),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Simple SRAM: combinational read of the addressed word, write on strobe.
    assign sram_rdata = sram_mem[sram_addr[9:0]];
    always @(posedge clk) begin
        if (sram_en && sram_we) sram_mem[sram_addr[9:0]] <= sram_wdata;
    end

    function automatic void check1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    function automatic void check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic is_mem, input logic [31:0] data, input int offset);
        exp_t e;
        e.is_mem = is_mem;
        e.data   = data;
        e.cyc    = cyc + offset;
        sb.push_back(e);
    endtask

    // Walks n cycles from the current (IDLE) cycle, checking the SRAM bus
    // against up to two access windows and freeze against its expected span;
    // requesters drop their request on their ready pulse.
    task automatic run_window(input int n, input int w0, input logic [29:0] a0,
                              input logic we0, input logic [31:0] wd0,
                              input int w1, input logic [29:0] a1, input int frz);
        int t0;
        int off;
        logic exp_en;
        logic exp_we;
        logic [29:0] exp_a;
        t0 = cyc;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            off    = cyc - t0;
            exp_en = 1'b0;
            exp_we = 1'b0;
            exp_a  = '0;
            if (off >= w0 && off < w0 + C_WAIT) begin
                exp_en = 1'b1;
                exp_we = we0;
                exp_a  = a0;
            end else if (w1 >= 0 && off >= w1 && off < w1 + C_WAIT) begin
                exp_en = 1'b1;
                exp_a  = a1;
            end
            check1("sram_en", sram_en, exp_en);
            check1("sram_we", sram_we, exp_we);
            if (exp_en) begin
                check32("sram_addr", {2'b00, sram_addr}, {2'b00, exp_a});
                if (exp_we) check32("sram_wdata", sram_wdata, wd0);
            end
            check1("freeze", freeze, off < frz);
            if (mem_ready) begin
                mem_r_en = 1'b0;
                mem_w_en = 1'b0;
            end
            if (if_ready) if_req = 1'b0;
        end
    endtask

    // Response monitor: every ready pulse must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (if_ready === 1'b1 || mem_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_ready: if_ready=%b mem_ready=%b with nothing outstanding (cycle %0d)",
                             if_ready, mem_ready, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check1("ready_mem_port", mem_ready, e.is_mem);
                    check1("ready_if_port", if_ready, !e.is_mem);
                    check32("ready_cycle", cyc, e.cyc);
                    check32(e.is_mem ? "mem_rdata" : "if_rdata",
                            e.is_mem ? mem_rdata : if_rdata, e.data);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) sram_mem[i] = 32'h0;
        sram_mem[4]    = 32'hE3A0_1005;
        sram_mem[5]    = 32'h1111_2222;
        sram_mem[6]    = 32'hA5A5_5A5A;
        sram_mem[8]    = 32'h1234_5678;
        sram_mem[16]   = 32'h0BB0_0BB0;

        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        mem_r_en = 1'b0; mem_w_en = 1'b0; mem_addr = '0; mem_wdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("rst_if_rdata", if_rdata, 32'h0);
        check32("rst_mem_rdata", mem_rdata, 32'h0);
        check1("rst_if_ready", if_ready, 1'b0);
        check1("rst_mem_ready", mem_ready, 1'b0);
        check1("rst_sram_en", sram_en, 1'b0);
        check1("rst_sram_we", sram_we, 1'b0);
        check32("rst_sram_addr", {2'b00, sram_addr}, 32'h0);
        check32("rst_sram_wdata", sram_wdata, 32'h0);
        check1("rst_freeze", freeze, 1'b0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Fetch read
        if_req = 1'b1; if_addr = 32'h0000_0010;
        push(1'b0, 32'hE3A0_1005, 5);
        run_window(6, 1, 30'h4, 1'b0, 32'h0, -1, 30'h0, 5);
        next_cycle();

        // Data write; inputs scrambled mid-access must not reach the SRAM bus
        mem_w_en = 1'b1; mem_addr = 32'h0000_0400; mem_wdata = 32'hDEAD_BEEF;
        push(1'b1, 32'h0, 5);
        fork
            begin
                repeat (2) @(posedge clk);
                #1;
                mem_addr  = 32'hFFFF_FFFC;
                mem_wdata = 32'h0000_0000;
            end
        join_none
        run_window(6, 1, 30'h100, 1'b1, 32'hDEAD_BEEF, -1, 30'h0, 5);
        next_cycle();

        // Simultaneous fetch and load: data first, fetch afterwards
        if_req = 1'b1; if_addr = 32'h0000_0018;
        mem_r_en = 1'b1; mem_addr = 32'h0000_0020;
        push(1'b1, 32'h1234_5678, 5);
        push(1'b0, 32'hA5A5_5A5A, 11);
        run_window(12, 1, 30'h8, 1'b0, 32'h0, 7, 30'h6, 11);
        next_cycle();

        // Read and write together behave as a write
        mem_r_en = 1'b1; mem_w_en = 1'b1; mem_addr = 32'h0000_0030; mem_wdata = 32'h0F0F_F0F0;
        push(1'b1, 32'h1234_5678, 5);
        run_window(6, 1, 30'hC, 1'b1, 32'h0F0F_F0F0, -1, 30'h0, 5);
        next_cycle();

        // Read back both written words
        mem_r_en = 1'b1; mem_addr = 32'h0000_0030; mem_wdata = 32'h5555_5555;
        push(1'b1, 32'h0F0F_F0F0, 5);
        run_window(6, 1, 30'hC, 1'b0, 32'h0, -1, 30'h0, 5);
        next_cycle();
        mem_r_en = 1'b1; mem_addr = 32'h0000_0400;
        push(1'b1, 32'hDEAD_BEEF, 5);
        run_window(6, 1, 30'h100, 1'b0, 32'h0, -1, 30'h0, 5);
        next_cycle();
        check32("if_rdata_hold", if_rdata, 32'hA5A5_5A5A);

        // Reset in the second ACCESS cycle aborts; the re-request completes
        if_req = 1'b1; if_addr = 32'h0000_0040;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check1("abort_pre_en", sram_en, 1'b1);
        next_cycle();
        rst = 1'b0;
        check1("abort_sram_en", sram_en, 1'b0);
        check32("abort_if_rdata", if_rdata, 32'h0);
        check32("abort_mem_rdata", mem_rdata, 32'h0);
        push(1'b0, 32'h0BB0_0BB0, 5);
        run_window(6, 1, 30'h10, 1'b0, 32'h0, -1, 30'h0, 5);
        next_cycle();

        // Back-to-back fetches
        if_req = 1'b1; if_addr = 32'h0000_0010;
        push(1'b0, 32'hE3A0_1005, 5);
        run_window(6, 1, 30'h4, 1'b0, 32'h0, -1, 30'h0, 5);
        next_cycle();
        if_req = 1'b1; if_addr = 32'h0000_0014;
        push(1'b0, 32'h1111_2222, 5);
        run_window(6, 1, 30'h5, 1'b0, 32'h0, -1, 30'h0, 5);

        repeat (4) next_cycle();
        check1("final_sram_en", sram_en, 1'b0);
        check32("scoreboard_drain", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
